// File: rtl/mem_pkg.sv
// Shared definitions for the two-port byte-enable SRAM: zero-fill FSM states,
// read-latency helper and the byte-lane merge used by writes and the read bypass.
package mem_pkg;

    // Widest data word byte_merge can handle; callers zero-extend and truncate.
    localparam int unsigned MaxDwidth = 512;
    localparam int unsigned MaxBytes  = MaxDwidth / 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } clr_state_e;

    function automatic int unsigned calc_lat(input int unsigned out_reg);
        return (out_reg != 0) ? 2 : 1;
    endfunction

    function automatic logic [MaxDwidth-1:0] byte_merge(
        input logic [MaxDwidth-1:0] old_w,
        input logic [MaxDwidth-1:0] new_w,
        input logic [MaxBytes-1:0]  be
    );
        logic [MaxDwidth-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MaxBytes); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tp_sram_clear_seq.sv
// Zero-fill sequencer: walks the word counter 0..SIZE-1 once per cycle while BUSY,
// started by a CLR pulse or, optionally, automatically after reset.
module tp_sram_clear_seq
    import mem_pkg::*;
#(
    parameter int unsigned AWIDTH         = 12,
    parameter int unsigned SIZE           = 4096,
    parameter int unsigned CLEAR_ON_RESET = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              we_o,
    output logic [AWIDTH-1:0] addr_o
);

    localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(SIZE - 1);

    clr_state_e        state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    // Pending auto-start; set by reset so the fill begins on the first edge after RST drops.
    logic              auto_q, auto_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_i || auto_q) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            auto_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        busy_o = (state_q == StClear);
        we_o   = busy_o;
        addr_o = cnt_q;
    end

endmodule

// File: rtl/tp_sram_be.sv
// Two-port (1R + 1W) synchronous SRAM with byte enables, selectable read-during-write
// policy, optional output register and a hardware zero-fill sequencer.
module tp_sram_be
    import mem_pkg::*;
#(
    parameter              ROMDATA        = "",
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 12,
    parameter int unsigned SIZE           = 4096,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned WRITE_FIRST    = 1,
    parameter int unsigned CLEAR_ON_RESET = 0,
    localparam int unsigned NBYTES        = DWIDTH / 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              RCSN,
    input  logic [AWIDTH-1:0] RADDR,
    output logic [DWIDTH-1:0] DOUT,
    output logic              RVALID,
    input  logic              WCSN,
    input  logic [AWIDTH-1:0] WADDR,
    input  logic [NBYTES-1:0] BE,
    input  logic [DWIDTH-1:0] DI
);

    localparam int unsigned       LAT   = calc_lat(OUT_REG);
    localparam int unsigned       IdxW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [AWIDTH:0]   SizeW = (AWIDTH + 1)'(SIZE);

    logic [DWIDTH-1:0] mem [SIZE];

    logic            clr_we;
    logic [IdxW-1:0] clr_addr;

    tp_sram_clear_seq #(
        .AWIDTH         (IdxW),
        .SIZE           (SIZE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (CLR),
        .busy_o (BUSY),
        .we_o   (clr_we),
        .addr_o (clr_addr)
    );

    logic              rd_acc, wr_acc, rd_in_range, wr_in_range;
    logic [IdxW-1:0]   ridx, widx, mem_idx;
    logic [DWIDTH-1:0] wr_old, wr_merged, rd_word, mem_wdata;
    logic              mem_we;

    always_comb begin
        rd_acc      = !RCSN && !BUSY;
        wr_acc      = !WCSN && !BUSY;
        rd_in_range = {1'b0, RADDR} < SizeW;
        wr_in_range = {1'b0, WADDR} < SizeW;
        ridx        = RADDR[IdxW-1:0];
        widx        = WADDR[IdxW-1:0];
        wr_old      = mem[widx];
        wr_merged   = DWIDTH'(byte_merge(MaxDwidth'(wr_old), MaxDwidth'(DI), MaxBytes'(BE)));

        // Same-address bypass is only taken when the write will actually land.
        if (!rd_in_range) begin
            rd_word = '0;
        end else if ((WRITE_FIRST != 0) && wr_acc && wr_in_range && (WADDR == RADDR)) begin
            rd_word = wr_merged;
        end else begin
            rd_word = mem[ridx];
        end

        // The fill owns the write port while it runs.
        if (BUSY) begin
            mem_we    = clr_we;
            mem_idx   = clr_addr;
            mem_wdata = '0;
        end else begin
            mem_we    = wr_acc && wr_in_range;
            mem_idx   = widx;
            mem_wdata = wr_merged;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    logic              stage_valid;
    logic [DWIDTH-1:0] stage_data;

    if (LAT > 1) begin : g_out_reg
        logic              s1_valid_q;
        logic [DWIDTH-1:0] s1_data_q, s1_data_d;

        always_comb s1_data_d = rd_acc ? rd_word : s1_data_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_acc;
                s1_data_q  <= s1_data_d;
            end
        end

        assign stage_valid = s1_valid_q;
        assign stage_data  = s1_data_q;
    end else begin : g_no_out_reg
        assign stage_valid = rd_acc;
        assign stage_data  = rd_word;
    end

    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              rvalid_q, rvalid_d;

    always_comb begin
        dout_d   = stage_valid ? stage_data : dout_q;
        rvalid_d = stage_valid;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign DOUT   = dout_q;
    assign RVALID = rvalid_q;

endmodule

// File: tb/tb_tp_sram_be.sv
// Directed bench: instance A (OUT_REG=0, WRITE_FIRST=1) and instance B
// (OUT_REG=1, WRITE_FIRST=0, CLEAR_ON_RESET=1), both 16 words with 5-bit addresses.
module tb_tp_sram_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_clr, a_rcsn, a_wcsn, a_busy, a_rvalid;
    logic [4:0]  a_raddr, a_waddr;
    logic [3:0]  a_be;
    logic [31:0] a_di, a_dout;

    logic        b_rst, b_clr, b_rcsn, b_wcsn, b_busy, b_rvalid;
    logic [4:0]  b_raddr, b_waddr;
    logic [3:0]  b_be;
    logic [31:0] b_di, b_dout;

    int n_cmp = 0;
    int n_err = 0;

    tp_sram_be #(
        .DWIDTH(32), .AWIDTH(5), .SIZE(16),
        .OUT_REG(0), .WRITE_FIRST(1), .CLEAR_ON_RESET(0)
    ) u_dut_a (
        .CLK(clk), .RST(a_rst), .CLR(a_clr), .BUSY(a_busy),
        .RCSN(a_rcsn), .RADDR(a_raddr), .DOUT(a_dout), .RVALID(a_rvalid),
        .WCSN(a_wcsn), .WADDR(a_waddr), .BE(a_be), .DI(a_di)
    );

    tp_sram_be #(
        .DWIDTH(32), .AWIDTH(5), .SIZE(16),
        .OUT_REG(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .CLK(clk), .RST(b_rst), .CLR(b_clr), .BUSY(b_busy),
        .RCSN(b_rcsn), .RADDR(b_raddr), .DOUT(b_dout), .RVALID(b_rvalid),
        .WCSN(b_wcsn), .WADDR(b_waddr), .BE(b_be), .DI(b_di)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_wcsn = 1'b0; a_waddr = addr; a_di = d; a_be = be;
        tick();
        a_wcsn = 1'b1;
    endtask

    task automatic b_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
        b_wcsn = 1'b0; b_waddr = addr; b_di = d; b_be = be;
        tick();
        b_wcsn = 1'b1;
    endtask

    task automatic test_reset();
        int a_busy_n, b_busy_n;
        a_rst = 1'b1; a_clr = 1'b0; a_rcsn = 1'b1; a_wcsn = 1'b1;
        a_raddr = '0; a_waddr = '0; a_be = '0; a_di = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_rcsn = 1'b1; b_wcsn = 1'b1;
        b_raddr = '0; b_waddr = '0; b_be = '0; b_di = '0;
        tick(); tick();
        n_cmp++; if (a_dout !== 32'h0) begin n_err++; $display("FAIL rst_a_dout: got %h want 0", a_dout); end
        n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_a_rvalid: got %b want 0", a_rvalid); end
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
        n_cmp++; if (b_dout !== 32'h0) begin n_err++; $display("FAIL rst_b_dout: got %h want 0", b_dout); end
        n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_b_rvalid: got %b want 0", b_rvalid); end
        n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
        a_rst = 1'b0; b_rst = 1'b0;
        // B fills automatically after reset; A must stay idle.
        a_busy_n = 0; b_busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_busy) a_busy_n++;
            if (b_busy) b_busy_n++;
            tick();
        end
        n_cmp++; if (b_busy_n !== 16) begin n_err++; $display("FAIL auto_fill_len: got %0d want 16", b_busy_n); end
        n_cmp++; if (a_busy_n !== 0) begin n_err++; $display("FAIL a_no_auto_fill: got %0d want 0", a_busy_n); end
    endtask

    task automatic test_write_read();
        a_write(5'd5, 32'hDEADBEEF, 4'hF);
        a_rcsn = 1'b0; a_raddr = 5'd5;
        tick();
        a_rcsn = 1'b1;
        n_cmp++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL wr_rd_rvalid: got %b want 1", a_rvalid); end
        n_cmp++; if (a_dout !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd_dout: got %h want deadbeef", a_dout); end
        tick();
        n_cmp++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse: got %b want 0", a_rvalid); end
        n_cmp++; if (a_dout !== 32'hDEADBEEF) begin n_err++; $display("FAIL dout_hold: got %h want deadbeef", a_dout); end
    endtask

    task automatic test_byte_enable();
        a_write(5'd5, 32'h11223344, 4'b0101);
        a_rcsn = 1'b0; a_raddr = 5'd5;
        tick();
        a_rcsn = 1'b1;
        n_cmp++; if (a_dout !== 32'hDE22BE44) begin n_err++; $display("FAIL be_merge: got %h want de22be44", a_dout); end
        a_write(5'd5, 32'hFFFFFFFF, 4'b0000);
        a_rcsn = 1'b0; a_raddr = 5'd5;
        tick();
        a_rcsn = 1'b1;
        n_cmp++; if (a_dout !== 32'hDE22BE44) begin n_err++; $display("FAIL be_zero_noop: got %h want de22be44", a_dout); end
    endtask

    task automatic test_read_during_write();
        a_write(5'd7, 32'h0, 4'hF);
        a_rcsn = 1'b0; a_raddr = 5'd7;
        a_wcsn = 1'b0; a_waddr = 5'd7; a_di = 32'hA5A5A5A5; a_be = 4'hF;
        tick();
        a_wcsn = 1'b1;
        n_cmp++; if (a_dout !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rdw_wf1: got %h want a5a5a5a5", a_dout); end
        tick();
        a_rcsn = 1'b1;
        n_cmp++; if (a_dout !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rdw_wf1_after: got %h want a5a5a5a5", a_dout); end

        b_write(5'd7, 32'h0, 4'hF);
        b_rcsn = 1'b0; b_raddr = 5'd7;
        b_wcsn = 1'b0; b_waddr = 5'd7; b_di = 32'hA5A5A5A5; b_be = 4'hF;
        tick();
        b_rcsn = 1'b1; b_wcsn = 1'b1;
        tick();
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h0) begin
            n_err++; $display("FAIL rdw_wf0: got rvalid=%b dout=%h want 1/00000000", b_rvalid, b_dout);
        end
        b_rcsn = 1'b0; b_raddr = 5'd7;
        tick();
        b_rcsn = 1'b1;
        tick();
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL rdw_wf0_after: got rvalid=%b dout=%h want 1/a5a5a5a5", b_rvalid, b_dout);
        end
    endtask

    task automatic test_clear_fill();
        int busy_n, rv_n;
        // Write on the same edge as CLR: it lands first, then the fill zeroes it.
        a_clr = 1'b1;
        a_wcsn = 1'b0; a_waddr = 5'd2; a_di = 32'h12345678; a_be = 4'hF;
        tick();
        a_clr = 1'b0; a_wcsn = 1'b1;
        busy_n = 0; rv_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (a_rvalid) rv_n++;
            if (a_busy) begin
                busy_n++;
                a_rcsn = 1'b0; a_raddr = 5'd5;
                a_wcsn = 1'b0; a_waddr = 5'd0; a_di = 32'hFFFFFFFF; a_be = 4'hF;
            end else begin
                a_rcsn = 1'b1; a_wcsn = 1'b1;
            end
            tick();
        end
        a_rcsn = 1'b1; a_wcsn = 1'b1;
        n_cmp++; if (busy_n !== 16) begin n_err++; $display("FAIL fill_busy_len: got %0d want 16", busy_n); end
        n_cmp++; if (rv_n !== 0) begin n_err++; $display("FAIL fill_no_rvalid: got %0d want 0", rv_n); end
        for (int i = 0; i < 16; i++) begin
            a_rcsn = 1'b0; a_raddr = 5'(i);
            tick();
            n_cmp++; if (a_rvalid !== 1'b1 || a_dout !== 32'h0) begin
                n_err++; $display("FAIL fill_word_%0d: got rvalid=%b dout=%h want 1/00000000", i, a_rvalid, a_dout);
            end
        end
        a_rcsn = 1'b1;
        tick();
    endtask

    task automatic test_out_of_range();
        a_write(5'd16, 32'hDEADBEEF, 4'hF);
        a_write(5'd1, 32'h0BADF00D, 4'hF);
        a_rcsn = 1'b0; a_raddr = 5'd0;
        tick();
        n_cmp++; if (a_dout !== 32'h0) begin n_err++; $display("FAIL oor_write_alias: got %h want 0", a_dout); end
        a_raddr = 5'd1;
        tick();
        n_cmp++; if (a_dout !== 32'h0BADF00D) begin n_err++; $display("FAIL oor_word1: got %h want 0badf00d", a_dout); end
        a_raddr = 5'd16;
        tick();
        a_rcsn = 1'b1;
        n_cmp++; if (a_rvalid !== 1'b1 || a_dout !== 32'h0) begin
            n_err++; $display("FAIL oor_read: got rvalid=%b dout=%h want 1/00000000", a_rvalid, a_dout);
        end
    endtask

    task automatic test_reset_mid_clear();
        int busy_n;
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (b_busy !== 1'b1 || b_dout !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL pre_abort: got busy=%b dout=%h want 1/a5a5a5a5", b_busy, b_dout);
        end
        b_rst = 1'b1;
        #1;
        n_cmp++; if (b_busy !== 1'b0 || b_dout !== 32'h0 || b_rvalid !== 1'b0) begin
            n_err++; $display("FAIL abort_async: got busy=%b dout=%h rvalid=%b want 0/0/0", b_busy, b_dout, b_rvalid);
        end
        tick();
        b_rst = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (b_busy) busy_n++;
            tick();
        end
        n_cmp++; if (busy_n !== 16) begin n_err++; $display("FAIL restart_len: got %0d want 16", busy_n); end
        b_rcsn = 1'b0; b_raddr = 5'd7;
        tick();
        b_rcsn = 1'b1;
        tick();
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h0) begin
            n_err++; $display("FAIL restart_word7: got rvalid=%b dout=%h want 1/00000000", b_rvalid, b_dout);
        end
    endtask

    task automatic test_back_to_back();
        b_write(5'd0, 32'h11110000, 4'hF);
        b_write(5'd1, 32'h22220001, 4'hF);
        b_write(5'd2, 32'h33330002, 4'hF);
        b_rcsn = 1'b0; b_raddr = 5'd0;
        tick();
        b_raddr = 5'd1;
        n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_lat: got rvalid=%b want 0", b_rvalid); end
        tick();
        b_raddr = 5'd2;
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h11110000) begin
            n_err++; $display("FAIL b2b_0: got rvalid=%b dout=%h want 1/11110000", b_rvalid, b_dout);
        end
        tick();
        b_raddr = 5'd20;
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h22220001) begin
            n_err++; $display("FAIL b2b_1: got rvalid=%b dout=%h want 1/22220001", b_rvalid, b_dout);
        end
        tick();
        b_rcsn = 1'b1;
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h33330002) begin
            n_err++; $display("FAIL b2b_2: got rvalid=%b dout=%h want 1/33330002", b_rvalid, b_dout);
        end
        tick();
        n_cmp++; if (b_rvalid !== 1'b1 || b_dout !== 32'h0) begin
            n_err++; $display("FAIL b2b_oor: got rvalid=%b dout=%h want 1/00000000", b_rvalid, b_dout);
        end
        tick();
        n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got rvalid=%b want 0", b_rvalid); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_read_during_write();
        test_clear_fill();
        test_out_of_range();
        test_reset_mid_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
